alu_control_pipe: RTL and testbench
===================================

ALU_CONTROL_PIPE -- requirements
Module: alu_control_pipe

Interface
REQ-001 SHALL have parameter LANES, default 1, number of instructions decoded per transfer (legal range 1..4).
REQ-002 SHALL have parameter OP_W, default 8, width of each alu_operation code.
REQ-003 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discards all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream bundle valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a bundle this cycle.
REQ-008 SHALL have port in_instruction  input  LANES*32  raw instruction per lane, lane 0 in LSBs.
REQ-009 SHALL have port in_alu_select  input  LANES*4  ALU select class per lane.
REQ-010 SHALL have port in_lane_valid  input  LANES  per-lane occupancy mask.
REQ-011 SHALL have port out_valid  output  1  decoded bundle valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts bundle.
REQ-013 SHALL have port out_alu_operation  output  LANES*OP_W  decoded operation per lane.
REQ-014 SHALL have port out_lane_valid  output  LANES  registered copy of in_lane_valid.
REQ-015 SHALL have port out_illegal  output  LANES  lane encoding not decodable.
REQ-016 SHALL have port decoded_count  output  32  count of completed output transfers.

Function
REQ-017 SHALL decode each lane independently: arithmetic (R/I, funct3+funct7), load, store, branch, JAL, JALR, LUI, AUIPC, NOP classes, per the isa package encodings.
REQ-018 SHALL flag out_illegal and force OP NOP for: unknown funct3 in load/store/branch; R-type funct7 other than 0x00/0x20 (0x01 when M enabled); funct7 0x20 with funct3 not ADD/SUB or SRL/SRA; unknown alu_select.
REQ-019 SHALL treat I-type (OPCODE_ALUI) funct3 ADD as ADD regardless of funct7; SRLI/SRAI still distinguished by funct7.
REQ-020 SHALL never flag illegal or decode on lanes with in_lane_valid=0; their op SHALL be NOP.
REQ-021 SHALL accept a bundle when in_valid && in_ready; decoded result appears on out_* the next cycle (latency 1).
REQ-022 SHALL implement a 2-entry skid buffer with states EMPTY, ONE, FULL; in_ready = (state != FULL), registered.
REQ-023 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without out handshake; ONE->EMPTY on out handshake without accept; ONE stays on both; FULL->ONE on out handshake (no accept possible).
REQ-024 SHALL present bundles in acceptance order; out_* SHALL hold stable while out_valid && !out_ready.
REQ-025 SHALL, on flush, go to EMPTY next cycle, drop any same-cycle accept, not count a same-cycle out handshake; flush SHALL win over all events.
REQ-026 SHALL increment decoded_count by 1 per out handshake, wrapping 0xFFFFFFFF->0.

Reset
REQ-027 SHALL on reset: state EMPTY, out_valid=0, in_ready=1, out_alu_operation=NOP, out_lane_valid=0, out_illegal=0, decoded_count=0.
REQ-028 Reset mid-transfer SHALL discard both entries; reset SHALL take priority over flush.

Configuration
REQ-029 Macro ALU_CONTROL_M_EXT_EN defined: R-type funct7 0x01 SHALL decode to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3.
REQ-030 Macro undefined: funct7 0x01 SHALL be illegal, op NOP; no M op codes referenced.

Structure
REQ-031 Opcode, funct3/funct7 constants, field index ranges, alu_select codes, OP_W-wide alu_operation codes (incl. M ops) and the skid state enum SHALL live in shared package isa_pkg.
REQ-032 Per-lane combinational decode SHALL be sub-module alu_op_decode, instantiated LANES times via generate.

Verification
REQ-033 LANES=1, ARITHMETIC, 0x00308133 then 0x40308133 -> ADD then SUB, illegal=0, count 2.
REQ-034 ARITHMETIC, 0x40335293 (SRAI) -> SRA; 0x40306133 (funct7 0x20, OR) -> NOP, illegal=1.
REQ-035 ARITHMETIC, 0x02308133: with ALU_CONTROL_M_EXT_EN -> MUL, illegal=0; without -> NOP, illegal=1.
REQ-036 out_ready=0 for 3 cycles, 3 accept attempts -> 2 accepted, in_ready=0, out_* stable; release -> order preserved, count 2.
REQ-037 FULL with flush and in_valid same cycle -> next cycle EMPTY, out_valid=0, count unchanged.
REQ-038 LANES=4, lane_valid=4'b0101 -> lanes 1,3 NOP, illegal 0; count preset 0xFFFFFFFF -> 0 after one transfer.

Source files
------------

// File: rtl/isa_pkg.sv
// isa_pkg: shared encodings for the ALU control pipeline.
// Instruction field positions, opcode/funct constants, alu_select class
// codes, alu_operation codes (including the M-extension group) and the
// skid-buffer state type.
package isa_pkg;

  // Field geometry
  localparam int INSTR_W    = 32;
  localparam int SEL_W      = 4;
  localparam int ALU_OP_W   = 8;
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  // Opcodes used inside the arithmetic class
  localparam logic [6:0] OPCODE_ALU  = 7'b0110011;
  localparam logic [6:0] OPCODE_ALUI = 7'b0010011;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  // Arithmetic funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // M-extension funct3
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // alu_select instruction classes; codes 9..15 are undefined
  typedef enum logic [SEL_W-1:0] {
    SEL_NOP    = 4'd0,
    SEL_ARITH  = 4'd1,
    SEL_LOAD   = 4'd2,
    SEL_STORE  = 4'd3,
    SEL_BRANCH = 4'd4,
    SEL_JAL    = 4'd5,
    SEL_JALR   = 4'd6,
    SEL_LUI    = 4'd7,
    SEL_AUIPC  = 4'd8
  } alu_select_e;

  // alu_operation codes
  localparam logic [ALU_OP_W-1:0] OP_NOP    = 8'd0;
  localparam logic [ALU_OP_W-1:0] OP_ADD    = 8'd1;
  localparam logic [ALU_OP_W-1:0] OP_SUB    = 8'd2;
  localparam logic [ALU_OP_W-1:0] OP_SLL    = 8'd3;
  localparam logic [ALU_OP_W-1:0] OP_SLT    = 8'd4;
  localparam logic [ALU_OP_W-1:0] OP_SLTU   = 8'd5;
  localparam logic [ALU_OP_W-1:0] OP_XOR    = 8'd6;
  localparam logic [ALU_OP_W-1:0] OP_SRL    = 8'd7;
  localparam logic [ALU_OP_W-1:0] OP_SRA    = 8'd8;
  localparam logic [ALU_OP_W-1:0] OP_OR     = 8'd9;
  localparam logic [ALU_OP_W-1:0] OP_AND    = 8'd10;
  localparam logic [ALU_OP_W-1:0] OP_LB     = 8'd11;
  localparam logic [ALU_OP_W-1:0] OP_LH     = 8'd12;
  localparam logic [ALU_OP_W-1:0] OP_LW     = 8'd13;
  localparam logic [ALU_OP_W-1:0] OP_LBU    = 8'd14;
  localparam logic [ALU_OP_W-1:0] OP_LHU    = 8'd15;
  localparam logic [ALU_OP_W-1:0] OP_SB     = 8'd16;
  localparam logic [ALU_OP_W-1:0] OP_SH     = 8'd17;
  localparam logic [ALU_OP_W-1:0] OP_SW     = 8'd18;
  localparam logic [ALU_OP_W-1:0] OP_BEQ    = 8'd19;
  localparam logic [ALU_OP_W-1:0] OP_BNE    = 8'd20;
  localparam logic [ALU_OP_W-1:0] OP_BLT    = 8'd21;
  localparam logic [ALU_OP_W-1:0] OP_BGE    = 8'd22;
  localparam logic [ALU_OP_W-1:0] OP_BLTU   = 8'd23;
  localparam logic [ALU_OP_W-1:0] OP_BGEU   = 8'd24;
  localparam logic [ALU_OP_W-1:0] OP_JAL    = 8'd25;
  localparam logic [ALU_OP_W-1:0] OP_JALR   = 8'd26;
  localparam logic [ALU_OP_W-1:0] OP_LUI    = 8'd27;
  localparam logic [ALU_OP_W-1:0] OP_AUIPC  = 8'd28;
  localparam logic [ALU_OP_W-1:0] OP_MUL    = 8'd32;
  localparam logic [ALU_OP_W-1:0] OP_MULH   = 8'd33;
  localparam logic [ALU_OP_W-1:0] OP_MULHSU = 8'd34;
  localparam logic [ALU_OP_W-1:0] OP_MULHU  = 8'd35;
  localparam logic [ALU_OP_W-1:0] OP_DIV    = 8'd36;
  localparam logic [ALU_OP_W-1:0] OP_DIVU   = 8'd37;
  localparam logic [ALU_OP_W-1:0] OP_REM    = 8'd38;
  localparam logic [ALU_OP_W-1:0] OP_REMU   = 8'd39;

  // Output skid buffer occupancy
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational decode of one lane (instruction + alu_select)
// into an alu_operation code and an illegal flag.
// Optional feature macro: ALU_CONTROL_M_EXT_EN enables funct7=0x01 M ops.
module alu_op_decode
  import isa_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic [INSTR_W-1:0] instruction,
  input  logic [SEL_W-1:0]   alu_select,
  input  logic               lane_valid,
  output logic [OP_W-1:0]    alu_operation,
  output logic               illegal
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [ALU_OP_W-1:0] op_next;
  logic                bad_next;
  logic                unused_fields;

  assign opcode = instruction[OPCODE_MSB:OPCODE_LSB];
  assign funct3 = instruction[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7 = instruction[FUNCT7_MSB:FUNCT7_LSB];
  // Register/immediate fields do not affect the operation code
  assign unused_fields = ^{instruction[FUNCT7_LSB-1:FUNCT3_MSB+1],
                           instruction[FUNCT3_LSB-1:OPCODE_MSB+1]};

  // Class decode; any undecodable encoding collapses to NOP + illegal
  always_comb begin
    op_next  = OP_NOP;
    bad_next = 1'b0;
    case (alu_select)
      SEL_NOP: op_next = OP_NOP;
      SEL_ARITH: begin
        if (opcode == OPCODE_ALU) begin
          case (funct7)
            F7_BASE: begin
              case (funct3)
                F3_ADD_SUB: op_next = OP_ADD;
                F3_SLL:     op_next = OP_SLL;
                F3_SLT:     op_next = OP_SLT;
                F3_SLTU:    op_next = OP_SLTU;
                F3_XOR:     op_next = OP_XOR;
                F3_SRL_SRA: op_next = OP_SRL;
                F3_OR:      op_next = OP_OR;
                default:    op_next = OP_AND;
              endcase
            end
            F7_ALT: begin
              case (funct3)
                F3_ADD_SUB: op_next = OP_SUB;
                F3_SRL_SRA: op_next = OP_SRA;
                default:    bad_next = 1'b1;
              endcase
            end
`ifdef ALU_CONTROL_M_EXT_EN
            F7_MULDIV: begin
              case (funct3)
                F3_MUL:    op_next = OP_MUL;
                F3_MULH:   op_next = OP_MULH;
                F3_MULHSU: op_next = OP_MULHSU;
                F3_MULHU:  op_next = OP_MULHU;
                F3_DIV:    op_next = OP_DIV;
                F3_DIVU:   op_next = OP_DIVU;
                F3_REM:    op_next = OP_REM;
                default:   op_next = OP_REMU;
              endcase
            end
`else
            F7_MULDIV: bad_next = 1'b1;
`endif
            default: bad_next = 1'b1;
          endcase
        end else if (opcode == OPCODE_ALUI) begin
          // Immediate forms: upper bits are immediate except for the shift-right pair
          case (funct3)
            F3_ADD_SUB: op_next = OP_ADD;
            F3_SLL:     op_next = OP_SLL;
            F3_SLT:     op_next = OP_SLT;
            F3_SLTU:    op_next = OP_SLTU;
            F3_XOR:     op_next = OP_XOR;
            F3_SRL_SRA: begin
              if (funct7 == F7_BASE)     op_next  = OP_SRL;
              else if (funct7 == F7_ALT) op_next  = OP_SRA;
              else                       bad_next = 1'b1;
            end
            F3_OR:      op_next = OP_OR;
            default:    op_next = OP_AND;
          endcase
        end else begin
          bad_next = 1'b1;
        end
      end
      SEL_LOAD: begin
        case (funct3)
          F3_LB:   op_next = OP_LB;
          F3_LH:   op_next = OP_LH;
          F3_LW:   op_next = OP_LW;
          F3_LBU:  op_next = OP_LBU;
          F3_LHU:  op_next = OP_LHU;
          default: bad_next = 1'b1;
        endcase
      end
      SEL_STORE: begin
        case (funct3)
          F3_SB:   op_next = OP_SB;
          F3_SH:   op_next = OP_SH;
          F3_SW:   op_next = OP_SW;
          default: bad_next = 1'b1;
        endcase
      end
      SEL_BRANCH: begin
        case (funct3)
          F3_BEQ:  op_next = OP_BEQ;
          F3_BNE:  op_next = OP_BNE;
          F3_BLT:  op_next = OP_BLT;
          F3_BGE:  op_next = OP_BGE;
          F3_BLTU: op_next = OP_BLTU;
          F3_BGEU: op_next = OP_BGEU;
          default: bad_next = 1'b1;
        endcase
      end
      SEL_JAL:   op_next = OP_JAL;
      SEL_JALR:  op_next = OP_JALR;
      SEL_LUI:   op_next = OP_LUI;
      SEL_AUIPC: op_next = OP_AUIPC;
      default:   bad_next = 1'b1;
    endcase

    // Empty lanes never decode and never flag
    if (!lane_valid) begin
      op_next  = OP_NOP;
      bad_next = 1'b0;
    end else if (bad_next) begin
      op_next = OP_NOP;
    end
  end

  assign alu_operation = OP_W'(op_next);
  assign illegal       = bad_next;

endmodule

// File: rtl/alu_control_pipe.sv
// alu_control_pipe: LANES-wide ALU-control decoder behind a 2-entry output
// skid buffer (head drives out_*, skid catches the bundle accepted while the
// head is stalled). One-cycle latency, counts completed output transfers.
// Optional feature macro: ALU_CONTROL_M_EXT_EN (M-extension ops in decode).
module alu_control_pipe
  import isa_pkg::*;
#(
  parameter int LANES = 1,
  parameter int OP_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*INSTR_W-1:0] in_instruction,
  input  logic [LANES*SEL_W-1:0]  in_alu_select,
  input  logic [LANES-1:0]        in_lane_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OP_W-1:0]   out_alu_operation,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [LANES-1:0]        out_illegal,
  output logic [31:0]             decoded_count
);

  logic [LANES*OP_W-1:0] dec_op;
  logic [LANES-1:0]      dec_ill;

  skid_state_e           state_reg;
  skid_state_e           state_next;
  logic                  in_ready_reg;
  logic                  accept;
  logic                  out_hs;
  logic                  head_load_in;
  logic                  head_load_skid;
  logic                  skid_load;

  logic [LANES*OP_W-1:0] head_op_reg;
  logic [LANES-1:0]      head_lv_reg;
  logic [LANES-1:0]      head_ill_reg;
  logic [LANES*OP_W-1:0] skid_op_reg;
  logic [LANES-1:0]      skid_lv_reg;
  logic [LANES-1:0]      skid_ill_reg;
  logic [31:0]           count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      alu_op_decode #(
        .OP_W(OP_W)
      ) u_decode (
        .instruction  (in_instruction[gi*INSTR_W +: INSTR_W]),
        .alu_select   (in_alu_select[gi*SEL_W +: SEL_W]),
        .lane_valid   (in_lane_valid[gi]),
        .alu_operation(dec_op[gi*OP_W +: OP_W]),
        .illegal      (dec_ill[gi])
      );
    end
  endgenerate

  assign accept = in_valid && in_ready_reg;
  assign out_hs = (state_reg != SKID_EMPTY) && out_ready;

  // Skid occupancy register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= SKID_EMPTY;
    else       state_reg <= state_next;
  end

  // Next occupancy and data-movement strobes; flush overrides every event
  always_comb begin
    state_next     = state_reg;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_next = SKID_EMPTY;
    end else begin
      case (state_reg)
        SKID_EMPTY: begin
          if (accept) begin
            state_next   = SKID_ONE;
            head_load_in = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && out_hs) begin
            head_load_in = 1'b1;
          end else if (accept) begin
            state_next = SKID_FULL;
            skid_load  = 1'b1;
          end else if (out_hs) begin
            state_next = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_hs) begin
            state_next     = SKID_ONE;
            head_load_skid = 1'b1;
          end
        end
        default: state_next = SKID_EMPTY;
      endcase
    end
  end

  // in_ready is a register so it never depends combinationally on out_ready
  always_ff @(posedge clk) begin
    if (reset) in_ready_reg <= 1'b1;
    else       in_ready_reg <= (state_next != SKID_FULL);
  end

  // Head entry: driven onto out_*, cleared to NOP when emptied by reset/flush
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_op_reg  <= '0;
      head_lv_reg  <= '0;
      head_ill_reg <= '0;
    end else if (head_load_in) begin
      head_op_reg  <= dec_op;
      head_lv_reg  <= in_lane_valid;
      head_ill_reg <= dec_ill;
    end else if (head_load_skid) begin
      head_op_reg  <= skid_op_reg;
      head_lv_reg  <= skid_lv_reg;
      head_ill_reg <= skid_ill_reg;
    end
  end

  // Skid entry: holds the second bundle while the head is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_op_reg  <= '0;
      skid_lv_reg  <= '0;
      skid_ill_reg <= '0;
    end else if (skid_load) begin
      skid_op_reg  <= dec_op;
      skid_lv_reg  <= in_lane_valid;
      skid_ill_reg <= dec_ill;
    end
  end

  // Completed-transfer counter; a handshake coinciding with flush is discarded
  always_ff @(posedge clk) begin
    if (reset)                count_reg <= '0;
    else if (out_hs && !flush) count_reg <= count_reg + 32'd1;
  end

  assign in_ready          = in_ready_reg;
  assign out_valid         = (state_reg != SKID_EMPTY);
  assign out_alu_operation = head_op_reg;
  assign out_lane_valid    = head_lv_reg;
  assign out_illegal       = head_ill_reg;
  assign decoded_count     = count_reg;

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb_alu_control_pipe: directed self-checking bench. dut1 is a LANES=1 build,
// dut4 a LANES=4 build. Expected values are hand-computed constants.
module tb_alu_control_pipe;

  // Hand-computed operation codes
  localparam logic [7:0] E_NOP = 8'd0;
  localparam logic [7:0] E_ADD = 8'd1;
  localparam logic [7:0] E_SUB = 8'd2;
  localparam logic [7:0] E_SRA = 8'd8;
  localparam logic [31:0] I_ADD  = 32'h00308133;
  localparam logic [31:0] I_SUB  = 32'h40308133;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_BADOR = 32'h40306133;
  localparam logic [31:0] I_MUL  = 32'h02308133;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt;

  // LANES=1 instance signals
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_instr;
  logic [3:0]  a_sel;
  logic [0:0]  a_lv_in, a_lv_out, a_ill;
  logic [7:0]  a_op;
  logic [31:0] a_cnt;

  // LANES=4 instance signals
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [127:0] b_instr;
  logic [15:0]  b_sel;
  logic [3:0]   b_lv_in, b_lv_out, b_ill;
  logic [31:0]  b_op;
  logic [31:0]  b_cnt;

  always #5 clk = ~clk;

  alu_control_pipe #(.LANES(1), .OP_W(8)) dut1 (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instruction(a_instr), .in_alu_select(a_sel), .in_lane_valid(a_lv_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_alu_operation(a_op), .out_lane_valid(a_lv_out), .out_illegal(a_ill),
    .decoded_count(a_cnt)
  );

  alu_control_pipe #(.LANES(4), .OP_W(8)) dut4 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instruction(b_instr), .in_alu_select(b_sel), .in_lane_valid(b_lv_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_alu_operation(b_op), .out_lane_valid(b_lv_out), .out_illegal(b_ill),
    .decoded_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_cnt = 32'd0;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_op !== E_NOP) begin failures++; $display("FAIL rst_op got=%0h exp=%0h", a_op, E_NOP); end
    checks++; if (a_lv_out !== 1'b0 || a_ill !== 1'b0) begin failures++; $display("FAIL rst_lv_ill got=%0b/%0b exp=0/0", a_lv_out, a_ill); end
    checks++; if (a_cnt !== 32'd0) begin failures++; $display("FAIL rst_count got=%0h exp=0", a_cnt); end
    checks++; if (b_op !== 32'd0 || b_in_ready !== 1'b1) begin failures++; $display("FAIL rst4 got=%0h/%0b exp=0/1", b_op, b_in_ready); end
    $display("txn reset done");
  endtask

  task automatic test_add_sub();
    a_in_valid = 1'b1; a_instr = I_ADD; a_sel = 4'd1; a_lv_in = 1'b1; a_out_ready = 1'b1;
    tick();
    $display("txn add op=%0h ill=%0b", a_op, a_ill);
    checks++; if (a_out_valid !== 1'b1 || a_op !== E_ADD) begin failures++; $display("FAIL add_op got=%0b/%0h exp=1/%0h", a_out_valid, a_op, E_ADD); end
    checks++; if (a_ill !== 1'b0 || a_lv_out !== 1'b1) begin failures++; $display("FAIL add_flags got=%0b/%0b exp=0/1", a_ill, a_lv_out); end
    a_instr = I_SUB;
    tick(); exp_cnt++;
    $display("txn sub op=%0h ill=%0b", a_op, a_ill);
    checks++; if (a_op !== E_SUB || a_ill !== 1'b0) begin failures++; $display("FAIL sub_op got=%0h/%0b exp=%0h/0", a_op, a_ill, E_SUB); end
    a_in_valid = 1'b0;
    tick(); exp_cnt++;
    checks++; if (a_cnt !== 32'd2) begin failures++; $display("FAIL add_sub_count got=%0d exp=2", a_cnt); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL add_sub_drain got=%0b exp=0", a_out_valid); end
  endtask

  task automatic test_shift_illegal();
    a_in_valid = 1'b1; a_instr = I_SRAI;
    tick();
    $display("txn srai op=%0h ill=%0b", a_op, a_ill);
    checks++; if (a_op !== E_SRA || a_ill !== 1'b0) begin failures++; $display("FAIL srai got=%0h/%0b exp=%0h/0", a_op, a_ill, E_SRA); end
    a_instr = I_BADOR;
    tick(); exp_cnt++;
    $display("txn bad_or op=%0h ill=%0b", a_op, a_ill);
    checks++; if (a_op !== E_NOP || a_ill !== 1'b1) begin failures++; $display("FAIL f7_or got=%0h/%0b exp=%0h/1", a_op, a_ill, E_NOP); end
    a_instr = I_ADD; a_sel = 4'd12;
    tick(); exp_cnt++;
    $display("txn bad_sel op=%0h ill=%0b", a_op, a_ill);
    checks++; if (a_op !== E_NOP || a_ill !== 1'b1) begin failures++; $display("FAIL bad_sel got=%0h/%0b exp=0/1", a_op, a_ill); end
    a_sel = 4'd1; a_in_valid = 1'b0;
    tick(); exp_cnt++;
    checks++; if (a_cnt !== exp_cnt) begin failures++; $display("FAIL shift_count got=%0d exp=%0d", a_cnt, exp_cnt); end
  endtask

  task automatic test_mext();
    logic [7:0] eop;
    logic       eill;
`ifdef ALU_CONTROL_M_EXT_EN
    eop = 8'd32; eill = 1'b0;
`else
    eop = E_NOP; eill = 1'b1;
`endif
    a_in_valid = 1'b1; a_instr = I_MUL;
    tick();
    $display("txn mul op=%0h ill=%0b", a_op, a_ill);
    checks++; if (a_op !== eop || a_ill !== eill) begin failures++; $display("FAIL mext got=%0h/%0b exp=%0h/%0b", a_op, a_ill, eop, eill); end
    a_in_valid = 1'b0;
    tick(); exp_cnt++;
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_instr = I_ADD;
    tick();
    checks++; if (a_in_ready !== 1'b1 || a_op !== E_ADD) begin failures++; $display("FAIL bp_c1 got=%0b/%0h exp=1/%0h", a_in_ready, a_op, E_ADD); end
    a_instr = I_SUB;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_op !== E_ADD) begin failures++; $display("FAIL bp_c2 got=%0b/%0h exp=0/%0h", a_in_ready, a_op, E_ADD); end
    a_instr = I_SRAI;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_op !== E_ADD || a_ill !== 1'b0) begin failures++; $display("FAIL bp_c3 got=%0b/%0b/%0h exp=0/1/%0h", a_in_ready, a_out_valid, a_op, E_ADD); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick(); exp_cnt++;
    $display("txn bp_release op=%0h", a_op);
    checks++; if (a_op !== E_SUB || a_out_valid !== 1'b1 || a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_order got=%0h/%0b/%0b exp=%0h/1/1", a_op, a_out_valid, a_in_ready, E_SUB); end
    tick(); exp_cnt++;
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== exp_cnt) begin failures++; $display("FAIL bp_drain got=%0b/%0d exp=0/%0d", a_out_valid, a_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_instr = I_ADD;
    tick();
    a_instr = I_SUB;
    tick();
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_fill got=%0b exp=0", a_in_ready); end
    a_flush = 1'b1; a_instr = I_SRAI; a_out_ready = 1'b1;
    tick();
    $display("txn flush valid=%0b cnt=%0d", a_out_valid, a_cnt);
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0b/%0b exp=0/1", a_out_valid, a_in_ready); end
    checks++; if (a_cnt !== exp_cnt) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", a_cnt, exp_cnt); end
    a_flush = 1'b0; a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%0b exp=0", a_out_valid); end
  endtask

  task automatic test_reset_priority();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_instr = I_ADD;
    tick();
    reset = 1'b1; a_flush = 1'b1;
    tick();
    reset = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0;
    exp_cnt = 32'd0;
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 32'd0 || a_op !== E_NOP) begin failures++; $display("FAIL rst_mid got=%0b/%0d/%0h exp=0/0/0", a_out_valid, a_cnt, a_op); end
    $display("txn reset_mid done");
  endtask

  task automatic test_lanes4();
    force dut4.count_reg = 32'hFFFF_FFFF;
    tick();
    release dut4.count_reg;
    b_out_ready = 1'b1; b_in_valid = 1'b1;
    b_instr = {I_BADOR, I_SUB, I_BADOR, I_ADD};
    b_sel = 16'h1111; b_lv_in = 4'b0101;
    tick();
    $display("txn lanes4_a op=%08h ill=%0b", b_op, b_ill);
    checks++; if (b_op !== 32'h0002_0001) begin failures++; $display("FAIL l4_op got=%08h exp=00020001", b_op); end
    checks++; if (b_ill !== 4'b0000 || b_lv_out !== 4'b0101) begin failures++; $display("FAIL l4_flags got=%0b/%0b exp=0000/0101", b_ill, b_lv_out); end
    // lane3 JAL, lane2 branch funct3=3, lane1 undefined select, lane0 LW
    b_instr = {32'h0000006F, 32'h00003063, I_ADD, 32'h00002003};
    b_sel = 16'h54F2; b_lv_in = 4'b1111;
    tick();
    $display("txn lanes4_b op=%08h ill=%0b cnt=%0h", b_op, b_ill, b_cnt);
    checks++; if (b_cnt !== 32'd0) begin failures++; $display("FAIL l4_wrap got=%0h exp=0", b_cnt); end
    checks++; if (b_op !== 32'h1900_000D || b_ill !== 4'b0110) begin failures++; $display("FAIL l4_mix got=%08h/%0b exp=1900000d/0110", b_op, b_ill); end
    b_in_valid = 1'b0;
    tick();
    checks++; if (b_cnt !== 32'd1 || b_out_valid !== 1'b0) begin failures++; $display("FAIL l4_count got=%0h/%0b exp=1/0", b_cnt, b_out_valid); end
  endtask

  initial begin
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_instr = '0; a_sel = '0; a_lv_in = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_instr = '0; b_sel = '0; b_lv_in = '0;
    exp_cnt = 32'd0;
    test_reset();
    test_add_sub();
    test_shift_illegal();
    test_mext();
    test_back_to_back();
    test_flush();
    test_reset_priority();
    test_lanes4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
